alu_result_stage: RTL and testbench

//  Execute/writeback boundary stage directly downstream of the ALU. Captures ALU result
//  y and flags into a DEPTH-entry in-order buffer with valid/ready handshakes, and owns
//  the flag register FR. It evaluates branch conditions against FR and hands results to

---
 rtl/alu_result_stage.sv | 156 +++++++++++++++
 tb/tb_alu_result_stage.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_result_stage.sv
// ---------------------------------------------------------------------------
// alu_result_stage
//
// Execute/writeback boundary directly behind the ALU. ALU results are queued
// in a small in-order buffer with valid/ready handshakes on both sides. The
// stage also owns the flag register FR. Conditional branches are evaluated
// against FR when they enter the buffer. The pass/fail outcome travels with
// the entry to writeback.
//
// Ports
//   clk, rst_n        clock (rising edge), asynchronous active-low reset
//   flush             synchronous drop of all buffered entries (FR kept)
//   in_valid/in_ready upstream handshake; in_ready = buffer not full
//   in_y, in_flags    ALU result and its flags
//   in_rd, in_we      destination register and write enable
//   in_fr_we          load in_flags into FR when the entry is accepted
//   in_is_br, in_cond conditional branch marker and condition code
//   out_valid/out_ready  writeback handshake on the head entry
//   out_y, out_rd, out_we, out_br  head entry fields (zero when empty)
//   fr                current flag register (bit0 Z, bit1 N, bit2 C, bit3 V)
// ---------------------------------------------------------------------------
module alu_result_stage #(
    parameter int DATA_W     = 16,
    parameter int FR_FLAG_W  = 4,
    parameter int REG_ADDR_W = 3,
    parameter int DEPTH      = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_W-1:0]     in_y,
    input  logic [FR_FLAG_W-1:0]  in_flags,
    input  logic [REG_ADDR_W-1:0] in_rd,
    input  logic                  in_we,
    input  logic                  in_fr_we,
    input  logic                  in_is_br,
    input  logic [3:0]            in_cond,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_W-1:0]     out_y,
    output logic [REG_ADDR_W-1:0] out_rd,
    output logic                  out_we,
    output logic                  out_br,
    output logic [FR_FLAG_W-1:0]  fr
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [CNT_W-1:0]      count;
    logic [PTR_W-1:0]      rd_ptr;
    logic [PTR_W-1:0]      wr_ptr;
    logic [FR_FLAG_W-1:0]  fr_q;

    logic [DATA_W-1:0]     y_mem  [DEPTH];
    logic [REG_ADDR_W-1:0] rd_mem [DEPTH];
    logic                  we_mem [DEPTH];
    logic                  br_mem [DEPTH];

    logic push;
    logic pop;
    logic push_eff;
    logic br_taken;

    // Condition test against the flag register value before this edge.
    function automatic logic cond_holds(input logic [3:0] cond, input logic [FR_FLAG_W-1:0] f);
        logic z, n, c, v;
        z = f[0];
        n = f[1];
        c = f[2];
        v = f[3];
        case (cond)
            4'h0:    cond_holds = z;
            4'h1:    cond_holds = !z;
            4'h2:    cond_holds = c;
            4'h3:    cond_holds = !c;
            4'h4:    cond_holds = n;
            4'h5:    cond_holds = !n;
            4'h6:    cond_holds = v;
            4'h7:    cond_holds = !v;
            4'h8:    cond_holds = c && !z;
            4'h9:    cond_holds = !c || z;
            4'hA:    cond_holds = (n == v);
            4'hB:    cond_holds = (n != v);
            4'hC:    cond_holds = !z && (n == v);
            4'hD:    cond_holds = z || (n != v);
            4'hE:    cond_holds = 1'b1;
            default: cond_holds = 1'b0;
        endcase
    endfunction

    // in_ready depends only on registered occupancy, never on out_ready.
    assign in_ready  = (count != CNT_W'(DEPTH));
    assign out_valid = (count != '0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;
    assign push_eff  = push && !flush;
    assign br_taken  = in_is_br && cond_holds(in_cond, fr_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count  <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
            fr_q   <= '0;
        end else if (flush) begin
            // A push coinciding with flush is discarded along with its FR load.
            count  <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            if (push && !pop) begin
                count <= count + CNT_W'(1);
            end else if (pop && !push) begin
                count <= count - CNT_W'(1);
            end
            if (push && in_fr_we) begin
                fr_q <= in_flags;
            end
        end
    end

    // Payload storage needs no reset: outputs are masked while the buffer is empty.
    always_ff @(posedge clk) begin
        if (push_eff) begin
            y_mem[wr_ptr]  <= in_y;
            rd_mem[wr_ptr] <= in_rd;
            we_mem[wr_ptr] <= in_we;
            br_mem[wr_ptr] <= br_taken;
        end
    end

    always_comb begin
        out_y  = '0;
        out_rd = '0;
        out_we = 1'b0;
        out_br = 1'b0;
        if (out_valid) begin
            out_y  = y_mem[rd_ptr];
            out_rd = rd_mem[rd_ptr];
            out_we = we_mem[rd_ptr];
            out_br = br_mem[rd_ptr];
        end
    end

    assign fr = fr_q;

endmodule

// File: tb/tb_alu_result_stage.sv
// ---------------------------------------------------------------------------
// tb_alu_result_stage
//
// Directed scenarios followed by randomized traffic. A queue-based model of
// the buffer and flag register tracks the expected outputs; a compare process
// checks the DUT against it on every falling edge while out of reset.
// ---------------------------------------------------------------------------
module tb_alu_result_stage;

    localparam int DATA_W     = 16;
    localparam int FR_FLAG_W  = 4;
    localparam int REG_ADDR_W = 3;
    localparam int DEPTH      = 2;

    logic                  clk;
    logic                  rst_n;
    logic                  flush;
    logic                  in_valid;
    logic                  in_ready;
    logic [DATA_W-1:0]     in_y;
    logic [FR_FLAG_W-1:0]  in_flags;
    logic [REG_ADDR_W-1:0] in_rd;
    logic                  in_we;
    logic                  in_fr_we;
    logic                  in_is_br;
    logic [3:0]            in_cond;
    logic                  out_valid;
    logic                  out_ready;
    logic [DATA_W-1:0]     out_y;
    logic [REG_ADDR_W-1:0] out_rd;
    logic                  out_we;
    logic                  out_br;
    logic [FR_FLAG_W-1:0]  fr;

    int n_checks = 0;
    int n_errors = 0;

    alu_result_stage #(
        .DATA_W(DATA_W), .FR_FLAG_W(FR_FLAG_W), .REG_ADDR_W(REG_ADDR_W), .DEPTH(DEPTH)
    ) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_y(in_y), .in_flags(in_flags), .in_rd(in_rd), .in_we(in_we),
        .in_fr_we(in_fr_we), .in_is_br(in_is_br), .in_cond(in_cond),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_y(out_y), .out_rd(out_rd), .out_we(out_we), .out_br(out_br),
        .fr(fr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    typedef struct packed {
        logic [DATA_W-1:0]     y;
        logic [REG_ADDR_W-1:0] rd;
        logic                  we;
        logic                  br;
    } ent_t;

    ent_t                 mq[$];
    logic [FR_FLAG_W-1:0] m_fr;

    function automatic bit cond_true(input logic [3:0] c, input logic [3:0] f);
        bit z, n, cy, v;
        z = f[0]; n = f[1]; cy = f[2]; v = f[3];
        case (c)
            4'h0: return z;
            4'h1: return !z;
            4'h2: return cy;
            4'h3: return !cy;
            4'h4: return n;
            4'h5: return !n;
            4'h6: return v;
            4'h7: return !v;
            4'h8: return cy && !z;
            4'h9: return !cy || z;
            4'hA: return n == v;
            4'hB: return n != v;
            4'hC: return !z && (n == v);
            4'hD: return z || (n != v);
            4'hE: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mq.delete();
            m_fr = '0;
        end else begin
            bit acc, take;
            ent_t e;
            acc  = in_valid && (mq.size() < DEPTH);
            take = (mq.size() > 0) && out_ready;
            if (flush) begin
                mq.delete();
            end else begin
                if (take) void'(mq.pop_front());
                if (acc) begin
                    e.y  = in_y;
                    e.rd = in_rd;
                    e.we = in_we;
                    e.br = in_is_br && cond_true(in_cond, m_fr);
                    mq.push_back(e);
                    if (in_fr_we) m_fr = in_flags;
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            chk("cmp_in_ready", 32'(in_ready), 32'(mq.size() < DEPTH));
            chk("cmp_out_valid", 32'(out_valid), 32'(mq.size() != 0));
            chk("cmp_fr", 32'(fr), 32'(m_fr));
            if (mq.size() != 0) begin
                chk("cmp_out_y", 32'(out_y), 32'(mq[0].y));
                chk("cmp_out_rd", 32'(out_rd), 32'(mq[0].rd));
                chk("cmp_out_we", 32'(out_we), 32'(mq[0].we));
                chk("cmp_out_br", 32'(out_br), 32'(mq[0].br));
            end else begin
                chk("cmp_empty_y", 32'(out_y), 32'h0);
                chk("cmp_empty_br", 32'(out_br), 32'h0);
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic step;
        @(posedge clk);
        #2;
    endtask

    task automatic idle_inputs;
        flush = 0; in_valid = 0; in_y = '0; in_flags = '0; in_rd = '0;
        in_we = 0; in_fr_we = 0; in_is_br = 0; in_cond = '0;
    endtask

    initial begin
        idle_inputs();
        out_ready = 0;
        rst_n = 0;
        #12;
        chk("rst_out_valid", 32'(out_valid), 32'h0);
        chk("rst_in_ready", 32'(in_ready), 32'h1);
        chk("rst_fr", 32'(fr), 32'h0);
        chk("rst_out_y", 32'(out_y), 32'h0);
        step();
        rst_n = 1;
        step();

        // 1: simple push, visible next cycle
        out_ready = 1;
        in_valid = 1; in_y = 16'h0000; in_flags = 4'h1; in_fr_we = 1; in_we = 1; in_rd = 3'd1;
        step();
        idle_inputs();
        chk("t1_out_valid", 32'(out_valid), 32'h1);
        chk("t1_out_y", 32'(out_y), 32'h0000);
        chk("t1_fr", 32'(fr), 32'h1);
        chk("t1_model_fr", 32'(m_fr), 32'h1);
        step();

        // 2: ADD 7FFF+0001 sets N and V; later branches test against that FR
        in_valid = 1; in_y = 16'h8000; in_flags = 4'hA; in_fr_we = 1; in_we = 1; in_rd = 3'd3;
        step();
        chk("t2_out_y", 32'(out_y), 32'h8000);
        chk("t2_out_rd", 32'(out_rd), 32'h3);
        chk("t2_fr", 32'(fr), 32'hA);
        in_fr_we = 0; in_we = 0; in_y = 16'h0; in_is_br = 1; in_cond = 4'h6;
        step();
        chk("t2_vs_br", 32'(out_br), 32'h1);
        in_cond = 4'hA;
        step();
        chk("t2_ge_br", 32'(out_br), 32'h1);
        in_cond = 4'hB;
        step();
        chk("t2_lt_br", 32'(out_br), 32'h0);
        idle_inputs();
        step();

        // 3: backpressure then in-order drain
        out_ready = 0;
        in_valid = 1; in_y = 16'd1;
        step();
        in_y = 16'd2;
        step();
        chk("t3_in_ready_full", 32'(in_ready), 32'h0);
        chk("t3_head1", 32'(out_y), 32'h1);
        in_y = 16'd3;
        step();
        chk("t3_hold_ready", 32'(in_ready), 32'h0);
        chk("t3_head_stable", 32'(out_y), 32'h1);
        out_ready = 1;
        step();
        chk("t3_head2", 32'(out_y), 32'h2);
        step();
        in_valid = 0;
        chk("t3_head3", 32'(out_y), 32'h3);
        step();
        chk("t3_drained", 32'(out_valid), 32'h0);

        // 4: branch uses FR before the same-edge update
        out_ready = 0;
        in_valid = 1; in_fr_we = 1; in_flags = 4'h0;
        step();
        in_flags = 4'h4; in_is_br = 1; in_cond = 4'h2;
        step();
        idle_inputs();
        chk("t4_fr", 32'(fr), 32'h4);
        out_ready = 1;
        step();
        chk("t4_cs_br", 32'(out_br), 32'h0);
        step();

        // 5: flush of a full buffer discards the coinciding push and its FR load
        out_ready = 0;
        in_valid = 1; in_y = 16'd5;
        step();
        in_y = 16'd6;
        step();
        flush = 1; in_valid = 1; in_fr_we = 1; in_flags = 4'hF;
        step();
        idle_inputs();
        chk("t5_out_valid", 32'(out_valid), 32'h0);
        chk("t5_in_ready", 32'(in_ready), 32'h1);
        chk("t5_fr", 32'(fr), 32'h4);

        // 6: asynchronous reset between edges
        in_valid = 1; in_y = 16'h0011;
        step();
        step();
        in_valid = 0;
        @(posedge clk);
        #3 rst_n = 0;
        #1;
        chk("t6_rst_valid", 32'(out_valid), 32'h0);
        chk("t6_rst_ready", 32'(in_ready), 32'h1);
        chk("t6_rst_y", 32'(out_y), 32'h0);
        chk("t6_rst_fr", 32'(fr), 32'h0);
        @(posedge clk);
        #2 rst_n = 1;
        out_ready = 1;
        in_valid = 1; in_y = 16'hBEEF;
        step();
        idle_inputs();
        chk("t6_beef", 32'(out_y), 32'hBEEF);
        step();

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            flush     = ($urandom_range(0, 31) == 0);
            in_valid  = ($urandom_range(0, 9) < 6);
            out_ready = ($urandom_range(0, 9) < 7);
            in_y      = 16'($urandom);
            in_flags  = 4'($urandom);
            in_rd     = 3'($urandom);
            in_we     = 1'($urandom);
            in_fr_we  = 1'($urandom);
            in_is_br  = 1'($urandom);
            in_cond   = 4'($urandom);
            step();
        end
        idle_inputs();
        out_ready = 1;
        step();
        step();
        step();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
